mac_sat: RTL
============

// Module: mac_sat
// PURPOSE
//  Parametrised, pipelined multiply-accumulate engine with round-to-nearest and saturation.
//  Sums x[i]*a[i] for i = 0..n, then arithmetic-shifts the sum right by s, rounds and saturates to YW bits.
//  Drives i_o as the read address of external combinational coefficient/sample ROMs.
//  Signals completion with a one-cycle eof_o pulse; busy_o and ovf_o are outputs this block adds.
// PARAMETERS
//  XW    18         signed sample width (x_i)
//  AW    36         signed coefficient width (a_i)
//  YW    18         signed result width (y_o)
//  IW    6          index/count width (n_i, s_i, i_o); max terms = 2**IW
//  ACCW  XW+AW+IW   accumulator width; guard bits make overflow impossible for any n
// PORTS
//  clk_i   in   1    clock, rising edge
//  rst_ni  in   1    asynchronous reset, active low
//  stf_i   in   1    start pulse, sampled in IDLE only
//  x_i     in   XW   sample at address i_o, valid in the same cycle
//  a_i     in   AW   coefficient at address i_o, valid in the same cycle
//  n_i     in   IW   last term index (n+1 terms), latched at start
//  s_i     in   IW   right-shift amount, latched at start
//  y_o     out  YW   rounded/saturated result, held until next eof
//  i_o     out  IW   ROM address
//  busy_o  out  1    high from start-accept edge until the eof edge
//  eof_o   out  1    one-cycle pulse when y_o updates
//  ovf_o   out  1    saturation flag for current y_o, updates with eof_o
// BEHAVIOUR
//  Reset: state=IDLE; y_o=0, i_o=0, busy_o=0, eof_o=0, ovf_o=0; acc, prod_r, pv cleared.
//  FSM: IDLE -> RUN -> DRAIN -> OUT -> IDLE.
//  IDLE, on an edge with stf_i=1: latch n_i, s_i; acc<=0; i_o<=0; pv<=0; busy_o<=1; go to RUN.
//  RUN, every edge:
//    prod_r <= x_i*a_i (full XW+AW signed); pv <= 1.
//    If pv: acc <= acc + sext(prod_r).
//    If i_o==n: go to DRAIN. Otherwise i_o <= i_o+1.
//  DRAIN: acc <= acc + sext(prod_r); pv <= 0; go to OUT.
//  OUT: y_o <= sat(round(acc,s)); ovf_o <= sat flag; eof_o <= 1; busy_o <= 0; i_o <= 0; go to IDLE.
//  eof_o is cleared on every other edge.
//  Latency: start accepted at edge E0; eof_o rises at edge E0+n+3 and is high for exactly one cycle.
//  round(acc,s):
//    s==0: pass acc unchanged.
//    s>0: (acc + 2**(s-1)) >>> s, i.e. round half toward +inf.
//  sat: clamp to [-2**(YW-1), 2**(YW-1)-1]; ovf_o=1 iff clamping occurred.
//  Boundaries:
//    n=0: exactly one term.
//    n=2**IW-1: i_o stops at its maximum value and never wraps.
//    stf_i while busy_o=1 is ignored; a new run needs stf_i in IDLE.
//    stf_i on the edge of the OUT state is ignored. The earliest accepted restart is the next edge.
//    n_i/s_i changes mid-run have no effect.
//    rst_ni low mid-run aborts immediately to reset values; no eof_o is produced.
// STRUCTURE
//  Package mac_pkg:
//    state enum (IDLE, RUN, DRAIN, OUT);
//    default widths XW/AW/YW/IW;
//    function acc_width().
//  Sub-module mac_round_sat: purely combinational shift-round-saturate, parameterised on ACCW, YW, IW.
//  Outputs y and ovf; it is instantiated once, in the OUT path.
//  Top: FSM, index counter, product register, accumulator.
// TESTING
//  Fixed-point formats: x in A(7,10), a in A(7,28). Each test includes combinational ROM models.
//  1. x=1024, a=2**28 for all i; n=5, s=28; pulse stf
//     -> y_o=6144, ovf_o=0; eof_o high exactly at edge E0+8; busy_o high edges E0..E0+8.
//  2. Single term x=-1024, a=2**28; n=0, s=28
//     -> y_o=-1024 at E0+3; i_o only ever shows 0.
//  3. Rounding: product=3*2**27, n=0, s=28 -> y_o=2.
//     Same test with product=-3*2**27 -> y_o=-1.
//  4. All x=131071, all a=2**35-1; n=63, s=28 -> y_o=131071, ovf_o=1.
//     All x=-131072 -> y_o=-131072, ovf_o=1.
//  5. Re-pulse stf_i mid-run and again on the OUT edge
//     -> exactly one eof_o; a restart at the following edge succeeds.
//  6. Drop rst_ni at RUN cycle 3 -> all outputs 0 asynchronously, no eof_o.
//     After release, test 1 repeats bit-exactly.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types, default widths and width helper for the MAC engine
package mac_pkg;

   // Sequencer states: accumulate terms, flush the last product, publish result
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   localparam int XW_DEF = 18;
   localparam int AW_DEF = 36;
   localparam int YW_DEF = 18;
   localparam int IW_DEF = 6;

   // Product width plus one guard bit per possible index bit: 2**iw terms can never overflow
   function automatic int acc_width(input int xw, input int aw, input int iw);
      return xw + aw + iw;
   endfunction

endpackage

// File: rtl/mac_round_sat.sv
// rtl/mac_round_sat.sv - combinational arithmetic shift, round half up, saturate to YW bits
module mac_round_sat #(
   parameter int ACCW = 60,
   parameter int YW   = 18,
   parameter int IW   = 6
) (
   input  logic [ACCW-1:0] acc_i,
   input  logic [IW-1:0]   s_i,
   output logic [YW-1:0]   y_o,
   output logic            ovf_o
);

   // One extra bit so adding the rounding bias can never wrap
   localparam logic signed [ACCW:0] Y_MAX = {{(ACCW+2-YW){1'b0}}, {(YW-1){1'b1}}};
   localparam logic signed [ACCW:0] Y_MIN = {{(ACCW+2-YW){1'b1}}, {(YW-1){1'b0}}};
   localparam logic [YW-1:0]        Y_MAX_Y = {1'b0, {(YW-1){1'b1}}};
   localparam logic [YW-1:0]        Y_MIN_Y = {1'b1, {(YW-1){1'b0}}};

   logic signed [ACCW:0] acc_ext;
   logic signed [ACCW:0] bias;
   logic signed [ACCW:0] shifted;

   // Shift with rounding, then clamp into the signed YW range and flag any clamping
   always_comb begin
      acc_ext = $signed({acc_i[ACCW-1], acc_i});
      bias    = '0;
      if (s_i != '0) begin
         bias = (ACCW+1)'(1) << (s_i - IW'(1));
      end
      // Any shift of at least ACCW leaves acc + bias in [0, 2**s), which rounds to zero
      if (int'(s_i) >= ACCW) begin
         shifted = '0;
      end else begin
         shifted = (acc_ext + bias) >>> s_i;
      end
      y_o   = shifted[YW-1:0];
      ovf_o = 1'b0;
      if (shifted > Y_MAX) begin
         y_o   = Y_MAX_Y;
         ovf_o = 1'b1;
      end else if (shifted < Y_MIN) begin
         y_o   = Y_MIN_Y;
         ovf_o = 1'b1;
      end
   end

endmodule

// File: rtl/mac_sat.sv
// rtl/mac_sat.sv - pipelined multiply-accumulate sequencer with round and saturate output
module mac_sat
   import mac_pkg::*;
#(
   parameter int XW   = XW_DEF,
   parameter int AW   = AW_DEF,
   parameter int YW   = YW_DEF,
   parameter int IW   = IW_DEF,
   parameter int ACCW = acc_width(XW, AW, IW)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          stf_i,
   input  logic [XW-1:0] x_i,
   input  logic [AW-1:0] a_i,
   input  logic [IW-1:0] n_i,
   input  logic [IW-1:0] s_i,
   output logic [YW-1:0] y_o,
   output logic [IW-1:0] i_o,
   output logic          busy_o,
   output logic          eof_o,
   output logic          ovf_o
);

   localparam int PW = XW + AW;

   state_t             state_q, state_d;
   logic [IW-1:0]      n_q, n_d;
   logic [IW-1:0]      s_q, s_d;
   logic [IW-1:0]      i_q, i_d;
   logic [ACCW-1:0]    acc_q, acc_d;
   logic [PW-1:0]      prod_q, prod_d;
   logic               pv_q, pv_d;
   logic [YW-1:0]      y_q, y_d;
   logic               busy_q, busy_d;
   logic               eof_q, eof_d;
   logic               ovf_q, ovf_d;

   logic signed [PW-1:0] x_ext;
   logic signed [PW-1:0] a_ext;
   logic [ACCW-1:0]      prod_sext;
   logic [YW-1:0]        rs_y;
   logic                 rs_ovf;

   mac_round_sat #(
      .ACCW (ACCW),
      .YW   (YW),
      .IW   (IW)
   ) u_round_sat (
      .acc_i (acc_q),
      .s_i   (s_q),
      .y_o   (rs_y),
      .ovf_o (rs_ovf)
   );

   // Sequencer: one ROM read per RUN cycle, product registered, summed a cycle later
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      s_d       = s_q;
      i_d       = i_q;
      acc_d     = acc_q;
      prod_d    = prod_q;
      pv_d      = pv_q;
      y_d       = y_q;
      busy_d    = busy_q;
      eof_d     = 1'b0;
      ovf_d     = ovf_q;
      x_ext     = PW'($signed(x_i));
      a_ext     = PW'($signed(a_i));
      prod_sext = {{(ACCW-PW){prod_q[PW-1]}}, prod_q};
      case (state_q)
         IDLE: begin
            if (stf_i) begin
               n_d     = n_i;
               s_d     = s_i;
               acc_d   = '0;
               i_d     = '0;
               pv_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            prod_d = x_ext * a_ext;
            pv_d   = 1'b1;
            if (pv_q) begin
               acc_d = acc_q + prod_sext;
            end
            // Stop at the last index rather than wrapping, so n = 2**IW-1 is safe
            if (i_q == n_q) begin
               state_d = DRAIN;
            end else begin
               i_d = i_q + IW'(1);
            end
         end
         DRAIN: begin
            acc_d   = acc_q + prod_sext;
            pv_d    = 1'b0;
            state_d = OUT;
         end
         OUT: begin
            y_d     = rs_y;
            ovf_d   = rs_ovf;
            eof_d   = 1'b1;
            busy_d  = 1'b0;
            i_d     = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts a run without producing eof
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         n_q     <= '0;
         s_q     <= '0;
         i_q     <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
         pv_q    <= 1'b0;
         y_q     <= '0;
         busy_q  <= 1'b0;
         eof_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         s_q     <= s_d;
         i_q     <= i_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         pv_q    <= pv_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         eof_q   <= eof_d;
         ovf_q   <= ovf_d;
      end
   end

   assign y_o    = y_q;
   assign i_o    = i_q;
   assign busy_o = busy_q;
   assign eof_o  = eof_q;
   assign ovf_o  = ovf_q;

endmodule
